// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
package uart_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Default rclk cycles per serial bit.
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit. Cleared on the pop cycle so START is a full bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic bit_done_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise advance and wrap at the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done_o = en_i & (cnt_q == CNT_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops one word per frame from a first-word
// fall-through FIFO and sends it as start, LSB-first data, optional even
// parity, and stop. tx is driven from a register so the line never glitches.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic                  rclk,
  input  logic                  r_rst,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  r_inc,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic                  par_q,   par_d;
  logic                  tx_q,    tx_d;
  logic                  pop;
  logic                  bit_done;

  // The pop strobe is combinational so the FIFO advances on the same edge
  // that captures the head word; reset suppresses it.
  assign pop = (state_q == ST_IDLE) & ~EMPTY & ~r_rst;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk_i      (rclk),
    .rst_i      (r_rst),
    .clear_i    (pop),
    .en_i       (state_q != ST_IDLE),
    .bit_done_o (bit_done)
  );

  // Frame sequencing, shift register and parity capture; tx is derived from
  // the next state so the registered line lines up with the state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          shift_d = RD_DATA;
          par_d   = even_parity(RD_DATA);
          idx_d   = {IDX_W{1'b0}};
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_done) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = {IDX_W{1'b0}};
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  // State, datapath and line registers; reset drops any in-flight word.
  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      state_q <= ST_IDLE;
      shift_q <= {DATA_WIDTH{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign r_inc = pop;
  assign tx    = tx_q;
  // The pop cycle already belongs to the frame, so it counts as busy.
  assign busy  = (state_q != ST_IDLE) | pop;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: per-cycle frame vectors, FIFO
// queue model with a UART receiver, reset and empty-timing corner cases.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       r_rst;
  logic       empty0, empty1;
  logic [7:0] rd0, rd1;
  logic       r_inc0, tx0, busy0;
  logic       r_inc1, tx1, busy1;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
    .rclk(clk), .r_rst(r_rst), .EMPTY(empty0), .RD_DATA(rd0),
    .r_inc(r_inc0), .tx(tx0), .busy(busy0)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
    .rclk(clk), .r_rst(r_rst), .EMPTY(empty1), .RD_DATA(rd1),
    .r_inc(r_inc1), .tx(tx1), .busy(busy1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One frame vector: word, which DUT, bit count, line bits in send order.
  typedef struct {
    logic [7:0] word;
    bit         par;
    int         nbits;
    logic [0:10] bits;
  } frame_vec_t;

  frame_vec_t vecs[6];

  // Drive one word directly and check every cycle of its frame.
  task automatic run_frame(input frame_vec_t v);
    logic t, b, ri;
    @(posedge clk); #1;
    if (v.par) begin empty1 = 1'b0; rd1 = v.word; end
    else       begin empty0 = 1'b0; rd0 = v.word; end
    @(negedge clk);
    chk($sformatf("pop_rinc %h", v.word), v.par ? r_inc1 : r_inc0, 1'b1);
    chk($sformatf("pop_busy %h", v.word), v.par ? busy1 : busy0, 1'b1);
    chk($sformatf("pop_tx %h", v.word),   v.par ? tx1 : tx0, 1'b1);
    @(posedge clk); #1;
    empty0 = 1'b1;
    empty1 = 1'b1;
    for (int c = 1; c <= v.nbits * CPB; c++) begin
      @(negedge clk);
      t  = v.par ? tx1 : tx0;
      b  = v.par ? busy1 : busy0;
      ri = v.par ? r_inc1 : r_inc0;
      chk($sformatf("frame_tx %h cyc%0d", v.word, c), t, v.bits[(c - 1) / CPB]);
      chk($sformatf("frame_busy %h cyc%0d", v.word, c), b, 1'b1);
      chk($sformatf("frame_rinc %h cyc%0d", v.word, c), ri, 1'b0);
    end
    @(negedge clk);
    chk($sformatf("end_busy %h", v.word), v.par ? busy1 : busy0, 1'b0);
    chk($sformatf("end_tx %h", v.word),   v.par ? tx1 : tx0, 1'b1);
  endtask

  // FIFO model, pop tracking and UART receiver state for dut0.
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         pop_times[$];
  bit         gap_hold, pop_flag, prev_rinc, rst_release;
  int         rinc_cnt, cyc_n, decoded, proto_err, rx_err;
  bit         rx_act;
  int         rx_c;
  logic [7:0] rx_data;

  // One rclk cycle: apply the pop and FIFO outputs after the edge, then
  // sample dut0 on the falling edge and advance the receiver.
  task automatic cyc();
    logic [7:0] w;
    @(posedge clk); #1;
    if (pop_flag && fifo_q.size() > 0) exp_q.push_back(fifo_q.pop_front());
    if (rst_release) begin r_rst = 1'b0; rst_release = 1'b0; end
    empty0 = gap_hold || (fifo_q.size() == 0);
    rd0    = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    @(negedge clk);
    cyc_n++;
    if (r_inc0 && prev_rinc) proto_err++;
    if (r_inc0 && empty0)    proto_err++;
    if (r_inc0) begin rinc_cnt++; pop_times.push_back(cyc_n); end
    prev_rinc = r_inc0;
    pop_flag  = r_inc0;
    if (!rx_act) begin
      if (tx0 === 1'b0) begin rx_act = 1'b1; rx_c = 0; end
    end else begin
      rx_c++;
    end
    if (rx_act) begin
      if (rx_c == CPB / 2 && tx0 !== 1'b0) rx_err++;
      for (int k = 1; k <= 8; k++)
        if (rx_c == k * CPB + CPB / 2) rx_data[k - 1] = tx0;
      if (rx_c == 9 * CPB + CPB / 2) begin
        if (tx0 !== 1'b1) rx_err++;
        decoded++;
        if (exp_q.size() == 0) begin
          rx_err++;
        end else begin
          w = exp_q.pop_front();
          chk_int($sformatf("rx_word #%0d", decoded), int'(rx_data), int'(w));
        end
        rx_act = 1'b0;
      end
    end
  endtask

  task automatic drain(input int target, input int budget);
    int n = 0;
    while (decoded < target && n < budget) begin cyc(); n++; end
    chk_int("drain_done", decoded, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int err, rc, gap_err;
    vecs[0] = '{8'hA5, 1'b0, 10, 11'b01010010111};
    vecs[1] = '{8'hA5, 1'b1, 11, 11'b01010010101};
    vecs[2] = '{8'hA4, 1'b1, 11, 11'b00010010111};
    vecs[3] = '{8'h3C, 1'b0, 10, 11'b00011110011};
    vecs[4] = '{8'h00, 1'b0, 10, 11'b00000000011};
    vecs[5] = '{8'hFF, 1'b1, 11, 11'b01111111101};

    r_rst = 1'b1; empty0 = 1'b0; empty1 = 1'b0; rd0 = 8'h5A; rd1 = 8'h5A;
    gap_hold = 1'b0; pop_flag = 1'b0; prev_rinc = 1'b0; rst_release = 1'b0;
    rinc_cnt = 0; cyc_n = 0; decoded = 0; proto_err = 0; rx_err = 0;
    rx_act = 1'b0; rx_c = 0; rx_data = 8'h00;

    // Reset state, with EMPTY low to show the pop is held off.
    repeat (3) @(negedge clk);
    chk("rst_tx0", tx0, 1'b1);     chk("rst_busy0", busy0, 1'b0);
    chk("rst_rinc0", r_inc0, 1'b0); chk("rst_tx1", tx1, 1'b1);
    chk("rst_busy1", busy1, 1'b0);  chk("rst_rinc1", r_inc1, 1'b0);
    @(posedge clk); #1;
    empty0 = 1'b1; empty1 = 1'b1; r_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_tx0", tx0, 1'b1);
    chk("idle_busy0", busy0, 1'b0);

    // Table-driven single frames, with and without parity.
    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // EMPTY held high: nothing moves.
    err = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (r_inc0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) err++;
      if (r_inc1 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) err++;
    end
    chk_int("empty_hold", err, 0);

    // EMPTY drops in the last STOP cycle: the pop waits for IDLE.
    fifo_q.push_back(8'h96);
    cyc();
    chk("late_first_pop", r_inc0, 1'b1);
    repeat (39) cyc();
    fifo_q.push_back(8'h69);
    cyc();
    chk("no_pop_last_stop", r_inc0, 1'b0);
    cyc();
    chk("pop_after_stop", r_inc0, 1'b1);
    drain(2, 100);
    repeat (4) cyc();

    // Burst of 9 words: in order, 9 pops, 41 cycles pop to pop.
    decoded = 0; rinc_cnt = 0; pop_times.delete();
    for (int w = 8'hA0; w <= 8'hA8; w++) fifo_q.push_back(8'(w));
    drain(9, 9 * 41 + 20);
    chk_int("burst_pops", rinc_cnt, 9);
    gap_err = 0;
    for (int i = 1; i < pop_times.size(); i++)
      if (pop_times[i] - pop_times[i - 1] != 41) gap_err++;
    chk_int("burst_gap", gap_err, 0);
    repeat (4) cyc();

    // Reset during data bit 3 of 8'h3C with 8'h5A queued behind it.
    decoded = 0;
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'h5A);
    cyc();
    chk("rst_case_pop", r_inc0, 1'b1);
    repeat (18) cyc();
    chk("pre_rst_bit3", tx0, 1'b1);
    @(posedge clk); #2;
    r_rst = 1'b1;
    #1;
    chk("rst_mid_tx", tx0, 1'b1);
    chk("rst_mid_busy", busy0, 1'b0);
    chk("rst_mid_rinc", r_inc0, 1'b0);
    rx_act = 1'b0; exp_q.delete(); pop_flag = 1'b0; prev_rinc = 1'b0;
    rc = rinc_cnt;
    repeat (5) cyc();
    chk_int("no_pop_in_reset", rinc_cnt, rc);
    chk("rst_hold_busy", busy0, 1'b0);
    rst_release = 1'b1;
    drain(1, 60);
    chk_int("one_pop_after_rst", rinc_cnt, rc + 1);
    chk_int("fifo_drained_rst", fifo_q.size(), 0);
    repeat (4) cyc();

    // Random words with random EMPTY gaps through the receiver model.
    decoded = 0; rinc_cnt = 0;
    for (int i = 0; i < 64; i++) fifo_q.push_back(8'($urandom));
    begin
      int n = 0;
      while (decoded < 64 && n < 8000) begin
        if ($urandom_range(0, 9) == 0) gap_hold = !gap_hold;
        cyc();
        n++;
      end
    end
    gap_hold = 1'b0;
    chk_int("rand_decoded", decoded, 64);
    chk_int("rand_pops", rinc_cnt, 64);
    chk_int("rand_fifo_empty", fifo_q.size(), 0);

    chk_int("protocol", proto_err, 0);
    chk_int("rx_framing", rx_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
